// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one DataMemory between a CPU port (0) and a
// loader/debug port (1), with per-port locking and address validation.
module data_memory_arbiter #(
  parameter int  depth    = 50,
  parameter int  width    = 32,
  parameter int  BPW      = 4,
  parameter int  LOCK_MAX = 8,
  localparam int AW       = $clog2(depth * BPW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic             p0_lock,
  input  logic [AW-1:0]    p0_addr,
  input  logic [width-1:0] p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [width-1:0] p0_rdata,
  output logic             p0_err,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic             p1_lock,
  input  logic [AW-1:0]    p1_addr,
  input  logic [width-1:0] p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [width-1:0] p1_rdata,
  output logic             p1_err,
  output logic [AW-1:0]    mem_read_address,
  output logic [AW-1:0]    mem_write_address,
  output logic [width-1:0] mem_write_data,
  output logic             mem_write_en,
  output logic             mem_read_en,
  input  logic [width-1:0] mem_read_data
);

  localparam int          CW        = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);
  localparam logic [AW:0]   ADDR_END  = (AW + 1)'(depth * BPW);

  typedef enum logic [1:0] {OPEN, LOCK0, LOCK1} state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       err_q, err_d;
  logic [width-1:0] rdata_q [2];
  logic [width-1:0] rdata_d [2];

  logic [1:0]       req, we, lk, gnt;
  logic [AW-1:0]    addr  [2];
  logic [width-1:0] wdata [2];
  logic             sel, acc, bad, ok;
  logic [AW-1:0]    s_addr;

  assign req      = {p1_req, p0_req};
  assign we       = {p1_we, p0_we};
  assign lk       = {p1_lock, p0_lock};
  assign addr[0]  = p0_addr;
  assign addr[1]  = p1_addr;
  assign wdata[0] = p0_wdata;
  assign wdata[1] = p1_wdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      case (state_q)
        OPEN:    gnt = (req == 2'b11) ? (rr_ptr_q ? 2'b10 : 2'b01) : req;
        LOCK0:   gnt = {1'b0, req[0]};
        LOCK1:   gnt = {req[1], 1'b0};
        default: gnt = '0;
      endcase
    end
  end

  // A bad address is still granted (consumed) but never reaches memory.
  assign sel    = gnt[1];
  assign acc    = |gnt;
  assign s_addr = addr[sel];
  assign bad    = ((s_addr % AW'(BPW)) != '0) || ({1'b0, s_addr} >= ADDR_END);
  assign ok     = acc && !bad;

  assign mem_read_en       = ok && !we[sel];
  assign mem_write_en      = ok && we[sel];
  assign mem_read_address  = mem_read_en  ? s_addr     : '0;
  assign mem_write_address = mem_write_en ? s_addr     : '0;
  assign mem_write_data    = mem_write_en ? wdata[sel] : '0;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      OPEN: begin
        if (req == 2'b11 && acc) rr_ptr_d = ~sel;
        if (ok && lk[sel]) begin
          state_d    = sel ? LOCK1 : LOCK0;
          lock_cnt_d = '0;
        end
      end
      LOCK0, LOCK1: begin
        lock_cnt_d = lock_cnt_q + CW'(1);
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = OPEN;
          rr_ptr_d   = (state_q == LOCK0);
          lock_cnt_d = '0;
        end else if (acc && (bad || !lk[sel])) begin
          state_d    = OPEN;
          lock_cnt_d = '0;
        end
      end
      default: state_d = OPEN;
    endcase

    rvalid_d = gnt & {2{mem_read_en}};
    err_d    = gnt & {2{acc && bad}};
    for (int i = 0; i < 2; i++) rdata_d[i] = rvalid_d[i] ? mem_read_data : rdata_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OPEN;
      rr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  // Masking with reset hides a pulse left over from the grant just before reset.
  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid_q[0] && !reset;
  assign p1_rvalid = rvalid_q[1] && !reset;
  assign p0_err    = err_q[0] && !reset;
  assign p1_err    = err_q[1] && !reset;
  assign p0_rdata  = reset ? '0 : rdata_q[0];
  assign p1_rdata  = reset ? '0 : rdata_q[1];

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a small DataMemory model
// (50 words, combinational read, write on the rising edge).
module tb_data_memory_arbiter;

  logic        clk, reset;
  logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid, p0_err;
  logic [7:0]  p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid, p1_err;
  logic [7:0]  p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic [7:0]  mem_read_address, mem_write_address;
  logic [31:0] mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;

  logic [31:0] mem [0:49];
  int          n_assert = 0;
  int          n_fail   = 0;

  data_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_read_data = '0;
    if (int'(mem_read_address) < 200) mem_read_data = mem[int'(mem_read_address) / 4];
  end

  always @(posedge clk)
    if (mem_write_en && int'(mem_write_address) < 200)
      mem[int'(mem_write_address) / 4] <= mem_write_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, l0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic r1, w1, l1, input logic [7:0] a1, input logic [31:0] d1);
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 8'd0, 32'd0, 0, 0, 0, 8'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 50; i++) mem[i] = '0;
    reset = 1'b1;
    p0_req = 1; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    tick();
    tick();
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_p1_gnt", p1_gnt, 0);
    check("rst_mem_en", {mem_read_en, mem_write_en}, 0);
    check("rst_mem_addr", {mem_read_address, mem_write_address}, 0);
    check("rst_pulses", {p0_rvalid, p0_err, p1_rvalid, p1_err}, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    @(negedge clk);
    reset = 1'b0;
    p0_req = 0; p1_req = 0;

    // 1: p0 write then read of addr 0
    drive(1, 1, 0, 8'd0, 32'hFAB0, 0, 0, 0, 8'd0, 32'd0);
    check("t1_wr_gnt", {p0_gnt, p1_gnt}, 2'b10);
    check("t1_wr_en", {mem_write_en, mem_read_en}, 2'b10);
    check("t1_wr_data", mem_write_data, 32'hFAB0);
    tick();
    check("t1_wr_norvalid", p0_rvalid, 0);
    drive(1, 0, 0, 8'd0, 32'd0, 0, 0, 0, 8'd0, 32'd0);
    check("t1_rd_gnt", p0_gnt, 1);
    check("t1_rd_en", {mem_write_en, mem_read_en}, 2'b01);
    tick();
    check("t1_rvalid", p0_rvalid, 1);
    check("t1_rdata", p0_rdata, 32'hFAB0);
    idle();
    check("t1_idle_mem", {mem_read_en, mem_write_en, mem_read_address, mem_write_address, mem_write_data}, 0);
    tick();
    check("t1_rvalid_drop", p0_rvalid, 0);
    check("t1_rdata_hold", p0_rdata, 32'hFAB0);

    // preload words at 4 and 8
    drive(1, 1, 0, 8'd4, 32'h4444_0004, 0, 0, 0, 8'd0, 32'd0);
    tick();
    drive(0, 0, 0, 8'd0, 32'd0, 1, 1, 0, 8'd8, 32'h8888_0008);
    check("pre_p1_gnt", p1_gnt, 1);
    tick();

    // 2: both ports read, grants alternate starting with p0
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 8'd4, 32'd0, 1, 0, 0, 8'd8, 32'd0);
      check("t2_gnt", {p0_gnt, p1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      check("t2_rvalid", {p0_rvalid, p1_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k % 2 == 0) check("t2_p0_rdata", p0_rdata, 32'h4444_0004);
      else            check("t2_p1_rdata", p1_rdata, 32'h8888_0008);
    end
    idle();
    tick();

    // 3: p1 locked read/write of 12 while p0 requests continuously
    drive(1, 1, 0, 8'd16, 32'h1616, 1, 0, 1, 8'd12, 32'd0);
    check("t3_a_gnt", {p0_gnt, p1_gnt}, 2'b10);
    tick();
    drive(1, 1, 0, 8'd16, 32'h1616, 1, 0, 1, 8'd12, 32'd0);
    check("t3_b_gnt", {p0_gnt, p1_gnt}, 2'b01);
    check("t3_b_raddr", mem_read_address, 8'd12);
    tick();
    check("t3_b_rvalid", p1_rvalid, 1);
    check("t3_b_rdata", p1_rdata, 0);
    drive(1, 1, 0, 8'd16, 32'h1616, 1, 1, 0, 8'd12, 32'hC0DE);
    check("t3_c_gnt", {p0_gnt, p1_gnt}, 2'b01);
    check("t3_c_waddr", {mem_write_en, mem_write_address}, {1'b1, 8'd12});
    tick();
    drive(1, 1, 0, 8'd16, 32'h1616, 0, 0, 0, 8'd0, 32'd0);
    check("t3_d_gnt", p0_gnt, 1);
    tick();

    // 4: p0 keeps lock=1; forced release after 8 locked cycles
    drive(1, 0, 1, 8'd12, 32'd0, 1, 0, 0, 8'd16, 32'd0);
    check("t4_entry_gnt", {p0_gnt, p1_gnt}, 2'b10);
    tick();
    check("t4_rdata", p0_rdata, 32'hC0DE);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 1, 8'd12, 32'd0, 1, 0, 0, 8'd16, 32'd0);
      check("t4_locked_gnt", {p0_gnt, p1_gnt}, 2'b10);
      tick();
    end
    drive(1, 0, 1, 8'd12, 32'd0, 1, 0, 0, 8'd16, 32'd0);
    check("t4_release_gnt", {p0_gnt, p1_gnt}, 2'b01);
    tick();
    check("t4_p1_rvalid", p1_rvalid, 1);
    check("t4_p1_rdata", p1_rdata, 32'h1616);
    idle();
    tick();

    // 5: misaligned and out-of-range addresses, then the last legal word
    drive(1, 0, 0, 8'd6, 32'd0, 0, 0, 0, 8'd0, 32'd0);
    check("t5_mis_gnt", p0_gnt, 1);
    check("t5_mis_en", {mem_read_en, mem_write_en}, 0);
    tick();
    check("t5_mis_err", {p0_err, p0_rvalid}, 2'b10);
    check("t5_mis_rdata", p0_rdata, 32'hC0DE);
    drive(1, 0, 1, 8'd200, 32'd0, 0, 0, 0, 8'd0, 32'd0);
    check("t5_oor_gnt", p0_gnt, 1);
    check("t5_oor_en", {mem_read_en, mem_write_en}, 0);
    tick();
    check("t5_oor_err", {p0_err, p0_rvalid}, 2'b10);
    drive(0, 0, 0, 8'd0, 32'd0, 1, 0, 0, 8'd196, 32'd0);
    check("t5_nolock_gnt", p1_gnt, 1);
    check("t5_last_raddr", {mem_read_en, mem_read_address}, {1'b1, 8'd196});
    tick();
    check("t5_err_drop", p0_err, 0);
    check("t5_last_rvalid", {p1_rvalid, p1_err}, 2'b10);
    check("t5_last_rdata", p1_rdata, 0);

    // 6: reset in the cycle after a p1 read grant
    drive(1, 0, 0, 8'd0, 32'd0, 1, 0, 0, 8'd4, 32'd0);
    check("t6_pre_gnt", {p0_gnt, p1_gnt}, 2'b10);
    tick();
    drive(0, 0, 0, 8'd0, 32'd0, 1, 0, 0, 8'd4, 32'd0);
    check("t6_p1_gnt", p1_gnt, 1);
    tick();
    @(negedge clk);
    reset = 1'b1;
    p1_req = 1'b0;
    #1;
    check("t6_rst_rvalid", p1_rvalid, 0);
    check("t6_rst_rdata", {p0_rdata, p1_rdata}, 0);
    tick();
    check("t6_after_pulses", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
    check("t6_after_mem", {mem_read_en, mem_write_en, mem_read_address, mem_write_address, mem_write_data}, 0);
    reset = 1'b0;
    drive(1, 0, 0, 8'd0, 32'd0, 1, 0, 0, 8'd4, 32'd0);
    check("t6_rr_reset_gnt", {p0_gnt, p1_gnt}, 2'b10);
    tick();
    check("t6_post_rdata", {p0_rvalid, p0_rdata}, {1'b1, 32'hFAB0});
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
